// File: rtl/sha3_pkg.sv
// Shared SHA3 definitions: digest-mode encodings, sponge FSM encoding and
// the per-mode rate / digest-length table.
package sha3_pkg;

   typedef enum logic [1:0] {
      MODE_224 = 2'd0,
      MODE_256 = 2'd1,
      MODE_384 = 2'd2,
      MODE_512 = 2'd3
   } sha3Mode_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ABSORB = 2'd1,
      ST_PERM   = 2'd2,
      ST_DONE   = 2'd3
   } spongeState_t;

   localparam int unsigned DIGEST_MAX = 512;

   // Rate in bits for a digest mode.
   function automatic logic [10:0] rateBits(input sha3Mode_t mode);
      logic [10:0] r;
      case (mode)
         MODE_224: r = 11'd1152;
         MODE_256: r = 11'd1088;
         MODE_384: r = 11'd832;
         MODE_512: r = 11'd576;
         default:  r = 11'd576;
      endcase
      return r;
   endfunction

   // Digest length in bits for a digest mode.
   function automatic logic [9:0] digestBits(input sha3Mode_t mode);
      logic [9:0] d;
      case (mode)
         MODE_224: d = 10'd224;
         MODE_256: d = 10'd256;
         MODE_384: d = 10'd384;
         MODE_512: d = 10'd512;
         default:  d = 10'd512;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/keccak_sponge_reg.sv
// Keccak sponge state register and control. Absorbs pre-padded rate blocks
// into the state, hands the state to an external keccak-p engine and
// presents the truncated digest once the final block has been permuted.
module keccak_sponge_reg
   import sha3_pkg::*;
#(
   parameter int STATE_W  = 1600,
   parameter int RATE_MAX = 1152,
   parameter int CNT_W    = 16
) (
   input  logic                inClk,
   input  logic                inRstN,
   input  logic                inInit,
   input  logic [1:0]          inMode,
   input  logic                inAbsValid,
   output logic                outAbsReady,
   input  logic                inAbsLast,
   input  logic [RATE_MAX-1:0] inAbsData,
   output logic                outPermValid,
   output logic [STATE_W-1:0]  outPermState,
   input  logic                inPermDone,
   input  logic [STATE_W-1:0]  inPermData,
   output logic                outDigestValid,
   output logic [511:0]        outDigest,
   output logic [CNT_W-1:0]    outBlkCnt,
   output logic                outErr
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   spongeState_t       fsmR, nextFsmS;
   logic [STATE_W-1:0] stateR, nextStateS;
   sha3Mode_t          modeR, nextModeS;
   logic [CNT_W-1:0]   cntR, nextCntS;
   logic               errR, nextErrS;
   logic               lastR, nextLastS;

   logic               absReadyR, permValidR, digestValidR;
   logic [511:0]       digestR, nextDigestS;

   logic [RATE_MAX-1:0] rateMaskS;
   logic [511:0]        digestMaskS;
   logic [STATE_W-1:0]  absExtS;
   logic [10:0]         rateS;
   logic [9:0]          digestLenS;

   assign rateS      = rateBits(modeR);
   assign digestLenS = digestBits(nextModeS);

   // Bit mask selecting the rate portion of the absorb bus for the latched mode.
   always_comb begin
      rateMaskS = '0;
      for (int i = 0; i < RATE_MAX; i++) begin
         if (i < int'(rateS)) begin
            rateMaskS[i] = 1'b1;
         end else begin
            rateMaskS[i] = 1'b0;
         end
      end
   end

   // Bit mask selecting the digest-length portion of the state for the next mode.
   always_comb begin
      digestMaskS = '0;
      for (int i = 0; i < 512; i++) begin
         if (i < int'(digestLenS)) begin
            digestMaskS[i] = 1'b1;
         end else begin
            digestMaskS[i] = 1'b0;
         end
      end
   end

   // Absorb data confined to the rate and zero-extended to the state width.
   always_comb begin
      absExtS                 = '0;
      absExtS[RATE_MAX-1:0]   = inAbsData & rateMaskS;
   end

   // Next-state logic: inInit wins over everything, then per-state behaviour.
   always_comb begin
      nextFsmS   = fsmR;
      nextStateS = stateR;
      nextModeS  = modeR;
      nextCntS   = cntR;
      nextErrS   = errR;
      nextLastS  = lastR;
      if (inInit) begin
         nextFsmS   = ST_ABSORB;
         nextStateS = '0;
         nextModeS  = sha3Mode_t'(inMode);
         nextCntS   = '0;
         nextErrS   = 1'b0;
         nextLastS  = 1'b0;
      end else begin
         case (fsmR)
            ST_ABSORB: begin
               if (inAbsValid) begin
                  nextStateS = stateR ^ absExtS;
                  nextLastS  = inAbsLast;
                  nextFsmS   = ST_PERM;
                  if (cntR != CNT_MAX) begin
                     nextCntS = cntR + {{(CNT_W-1){1'b0}}, 1'b1};
                  end else begin
                     nextCntS = cntR;
                  end
               end else begin
                  nextFsmS = ST_ABSORB;
               end
               if (inPermDone) begin
                  nextErrS = 1'b1;
               end else begin
                  nextErrS = errR;
               end
            end
            ST_PERM: begin
               if (inPermDone) begin
                  nextStateS = inPermData;
                  if (lastR) begin
                     nextFsmS = ST_DONE;
                  end else begin
                     nextFsmS = ST_ABSORB;
                  end
               end else begin
                  nextFsmS = ST_PERM;
               end
            end
            ST_IDLE, ST_DONE: begin
               if (inPermDone) begin
                  nextErrS = 1'b1;
               end else begin
                  nextErrS = errR;
               end
            end
            default: begin
               nextFsmS = ST_IDLE;
            end
         endcase
      end
   end

   // Digest value the output register will hold next cycle (zero outside DONE).
   always_comb begin
      if (nextFsmS == ST_DONE) begin
         nextDigestS = nextStateS[511:0] & digestMaskS;
      end else begin
         nextDigestS = '0;
      end
   end

   // Sponge state, control registers and registered status outputs.
   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         fsmR         <= ST_IDLE;
         stateR       <= '0;
         modeR        <= MODE_512;
         cntR         <= '0;
         errR         <= 1'b0;
         lastR        <= 1'b0;
         absReadyR    <= 1'b0;
         permValidR   <= 1'b0;
         digestValidR <= 1'b0;
         digestR      <= '0;
      end else begin
         fsmR         <= nextFsmS;
         stateR       <= nextStateS;
         modeR        <= nextModeS;
         cntR         <= nextCntS;
         errR         <= nextErrS;
         lastR        <= nextLastS;
         absReadyR    <= (nextFsmS == ST_ABSORB);
         permValidR   <= (nextFsmS == ST_PERM);
         digestValidR <= (nextFsmS == ST_DONE);
         digestR      <= nextDigestS;
      end
   end

   assign outAbsReady    = absReadyR;
   assign outPermValid   = permValidR;
   assign outPermState   = stateR;
   assign outDigestValid = digestValidR;
   assign outDigest      = digestR;
   assign outBlkCnt      = cntR;
   assign outErr         = errR;

endmodule

// File: tb/tb_keccak_sponge_reg.sv
// Directed bench for keccak_sponge_reg: absorb/permute/digest flows,
// rate masking, error flag behaviour, init priority and reset mid-permutation.
module tb_keccak_sponge_reg;

   logic          clk;
   logic          rstN;
   logic          init;
   logic [1:0]    mode;
   logic          absValid;
   logic          absReady;
   logic          absLast;
   logic [1151:0] absData;
   logic          permValid;
   logic [1599:0] permState;
   logic          permDone;
   logic [1599:0] permData;
   logic          digestValid;
   logic [511:0]  digest;
   logic [15:0]   blkCnt;
   logic          err;

   int nCmp = 0;
   int nErr = 0;

   logic [1599:0] allOnes;
   logic [1599:0] a5Pat;
   logic [1599:0] expS;
   logic [1151:0] blk3c;

   keccak_sponge_reg dut (
      .inClk          (clk),
      .inRstN         (rstN),
      .inInit         (init),
      .inMode         (mode),
      .inAbsValid     (absValid),
      .outAbsReady    (absReady),
      .inAbsLast      (absLast),
      .inAbsData      (absData),
      .outPermValid   (permValid),
      .outPermState   (permState),
      .inPermDone     (permDone),
      .inPermData     (permData),
      .outDigestValid (digestValid),
      .outDigest      (digest),
      .outBlkCnt      (blkCnt),
      .outErr         (err)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
      int idx;
      int w;
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         idx = 0;
         for (int i = 1599; i >= 0; i--) begin
            if (obs[i] !== exp[i]) idx = i;
         end
         w = idx / 64;
         $error("FAIL %s: first differing bit %0d, observed word[%0d]=%h expected word[%0d]=%h",
                tag, idx, w, obs[w*64 +: 64], w, exp[w*64 +: 64]);
      end
   endtask

   initial begin
      allOnes  = '1;
      a5Pat    = {200{8'hA5}};
      blk3c    = {144{8'h3C}};
      rstN     = 1'b0;
      init     = 1'b0;
      mode     = 2'd0;
      absValid = 1'b0;
      absLast  = 1'b0;
      absData  = '0;
      permDone = 1'b0;
      permData = '0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready",  1600'(absReady),    1600'd0);
      check("rst_pvalid", 1600'(permValid),   1600'd0);
      check("rst_dvalid", 1600'(digestValid), 1600'd0);
      check("rst_digest", 1600'(digest),      1600'd0);
      check("rst_cnt",    1600'(blkCnt),      1600'd0);
      check("rst_err",    1600'(err),         1600'd0);
      check("rst_state",  permState,          1600'd0);
      rstN = 1'b1;
      step();

      // Mode 3: all-ones block only fills the 576-bit rate
      init = 1'b1; mode = 2'd3;
      step();
      init = 1'b0;
      check("m3_ready", 1600'(absReady), 1600'd1);
      check("m3_cnt0",  1600'(blkCnt),   1600'd0);
      absValid = 1'b1; absLast = 1'b1; absData = '1;
      step();
      absValid = 1'b0; absLast = 1'b0;
      expS = allOnes >> 1024;
      check("m3_state",  permState,          expS);
      check("m3_pvalid", 1600'(permValid),   1600'd1);
      check("m3_cnt1",   1600'(blkCnt),      1600'd1);
      check("m3_noready",1600'(absReady),    1600'd0);
      permDone = 1'b1; permData = allOnes;
      step();
      permDone = 1'b0;
      expS = allOnes >> 1088;
      check("m3_dvalid", 1600'(digestValid), 1600'd1);
      check("m3_digest", 1600'(digest),      expS);
      check("m3_pvoff",  1600'(permValid),   1600'd0);

      // Mode 0: capacity preloaded with ones, then a 1152-ones block
      init = 1'b1; mode = 2'd0;
      step();
      init = 1'b0;
      absValid = 1'b1; absData = '0; absLast = 1'b0;
      step();
      absValid = 1'b0;
      permDone = 1'b1; permData = allOnes;
      step();
      permDone = 1'b0;
      check("m0_preload", permState,       allOnes);
      check("m0_ready",   1600'(absReady), 1600'd1);
      check("m0_cnt1",    1600'(blkCnt),   1600'd1);
      absValid = 1'b1; absData = '1; absLast = 1'b1;
      step();
      absValid = 1'b0; absLast = 1'b0;
      expS = allOnes << 1152;
      check("m0_state",  permState,      expS);
      check("m0_cnt2",   1600'(blkCnt),  1600'd2);
      permDone = 1'b1; permData = allOnes;
      step();
      permDone = 1'b0;
      expS = allOnes >> 1376;
      check("m0_dvalid", 1600'(digestValid), 1600'd1);
      check("m0_digest", 1600'(digest),      expS);

      // Mode 1: two blocks, rate masking at 1088, 256-bit digest
      init = 1'b1; mode = 2'd1;
      step();
      init = 1'b0;
      absValid = 1'b1; absData = blk3c; absLast = 1'b0;
      step();
      absValid = 1'b0;
      expS = '0;
      expS[1087:0] = blk3c[1087:0];
      check("m1_pvalid", 1600'(permValid), 1600'd1);
      check("m1_mask",   permState,        expS);
      permDone = 1'b1; permData = a5Pat;
      step();
      permDone = 1'b0;
      check("m1_ready",   1600'(absReady),    1600'd1);
      check("m1_nodone",  1600'(digestValid), 1600'd0);
      absValid = 1'b1; absData = '0; absLast = 1'b1;
      step();
      absValid = 1'b0; absLast = 1'b0;
      permDone = 1'b1; permData = a5Pat;
      step();
      permDone = 1'b0;
      expS = '0;
      expS[255:0] = a5Pat[255:0];
      check("m1_dvalid", 1600'(digestValid), 1600'd1);
      check("m1_digest", 1600'(digest),      expS);
      check("m1_cnt2",   1600'(blkCnt),      1600'd2);
      permDone = 1'b1;
      step();
      permDone = 1'b0;
      check("done_err",  1600'(err),         1600'd1);
      check("done_stay", 1600'(digestValid), 1600'd1);

      // Stray inPermDone in ABSORB
      init = 1'b1; mode = 2'd2;
      step();
      init = 1'b0;
      check("init_clr_err", 1600'(err), 1600'd0);
      absValid = 1'b1; absData = '0; absLast = 1'b0;
      step();
      absValid = 1'b0;
      permDone = 1'b1; permData = a5Pat;
      step();
      permDone = 1'b0;
      check("abs_state", permState, a5Pat);
      permDone = 1'b1; permData = allOnes;
      step();
      permDone = 1'b0;
      check("stray_err",   1600'(err),      1600'd1);
      check("stray_state", permState,       a5Pat);
      check("stray_ready", 1600'(absReady), 1600'd1);
      init = 1'b1;
      step();
      init = 1'b0;
      check("reinit_err",   1600'(err), 1600'd0);
      check("reinit_state", permState,  1600'd0);

      // inInit together with a valid block
      init = 1'b1; mode = 2'd0; absValid = 1'b1; absData = '1;
      step();
      init = 1'b0; absValid = 1'b0;
      check("prio_cnt",    1600'(blkCnt),    1600'd0);
      check("prio_state",  permState,        1600'd0);
      check("prio_pvalid", 1600'(permValid), 1600'd0);
      check("prio_ready",  1600'(absReady),  1600'd1);

      // Reset during PERM, then a late inPermDone
      absValid = 1'b1; absData = '1;
      step();
      absValid = 1'b0;
      check("pr_pvalid", 1600'(permValid), 1600'd1);
      rstN = 1'b0;
      #2;
      check("ar_pvalid", 1600'(permValid), 1600'd0);
      check("ar_state",  permState,        1600'd0);
      step();
      rstN = 1'b1;
      permDone = 1'b1; permData = allOnes;
      step();
      permDone = 1'b0;
      check("late_err",    1600'(err),         1600'd1);
      check("late_state",  permState,          1600'd0);
      check("late_ready",  1600'(absReady),    1600'd0);
      check("late_pvalid", 1600'(permValid),   1600'd0);
      check("late_dvalid", 1600'(digestValid), 1600'd0);
      check("late_cnt",    1600'(blkCnt),      1600'd0);
      check("late_digest", 1600'(digest),      1600'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
